wt_dcache_rd_miss_resp: RTL



---
 rtl/config_pkg.sv | 22 ++
 rtl/wt_cache_pkg.sv | 17 +
 rtl/wt_dcache_way_sel.sv | 19 +
 rtl/wt_dcache_rd_miss_resp.sv | 102 ++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// config_pkg: minimal core configuration record consumed by the dcache miss responder.
package config_pkg;
    typedef struct packed {
        int unsigned PLEN;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned DCACHE_TAG_WIDTH;
        int unsigned DCACHE_OFFSET_WIDTH;
        int unsigned MEM_TID_WIDTH;
        int unsigned WG_ID_WIDTH;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        PLEN: 32,
        DCACHE_SET_ASSOC: 4,
        DCACHE_LINE_WIDTH: 128,
        DCACHE_TAG_WIDTH: 20,
        DCACHE_OFFSET_WIDTH: 4,
        MEM_TID_WIDTH: 4,
        WG_ID_WIDTH: 4
    };
endpackage

// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types for the write-through dcache read-miss responder.
package wt_cache_pkg;
    localparam config_pkg::cva6_cfg_t Cfg = config_pkg::cva6_cfg_empty;
    localparam int unsigned SET_ASSOC = Cfg.DCACHE_SET_ASSOC;
    localparam int unsigned WAY_W = SET_ASSOC > 1 ? $clog2(SET_ASSOC) : 1;

    typedef enum logic [1:0] {IDLE, MEM_REQ, WAIT_RTRN} miss_state_e;

    typedef struct packed {
        logic [Cfg.PLEN-1:0]        paddr;
        logic                       nc;
        logic [2:0]                 size;
        logic [Cfg.WG_ID_WIDTH-1:0] wid;
        logic [SET_ASSOC-1:0]       vld_bits;
        logic [WAY_W-1:0]           way;
    } miss_info_t;
endpackage

// File: rtl/wt_dcache_way_sel.sv
// wt_dcache_way_sel: picks the lowest invalid way, falling back to the round-robin way when the set is full.
module wt_dcache_way_sel #(
    parameter int unsigned SetAssoc = 4,
    localparam int unsigned WayW = SetAssoc > 1 ? $clog2(SetAssoc) : 1
) (
    input  logic [SetAssoc-1:0] vld_bits,
    input  logic [WayW-1:0]     rr_cnt,
    output logic [WayW-1:0]     way,
    output logic                all_vld
);
    logic [WayW-1:0] inv_way;

    always_comb begin
        inv_way = '0;
        for (int i = SetAssoc - 1; i >= 0; i--) inv_way = vld_bits[i] ? inv_way : WayW'(i);
        all_vld = &vld_bits;
        way = all_vld ? rr_cnt : inv_way;
    end
endmodule

// File: rtl/wt_dcache_rd_miss_resp.sv
// wt_dcache_rd_miss_resp: accepts one read miss, fetches the line from memory and writes it into the chosen way.
module wt_dcache_rd_miss_resp
    import wt_cache_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned DCACHE_CL_IDX_WIDTH = 0,
    parameter logic [CVA6Cfg.MEM_TID_WIDTH-1:0] RdTxId = 1,
    localparam int unsigned IdxW = DCACHE_CL_IDX_WIDTH > 0 ? DCACHE_CL_IDX_WIDTH : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   miss_req_i,
    output logic                                   miss_ack_o,
    output logic                                   miss_replay_o,
    input  logic                                   miss_nc_i,
    input  logic                                   miss_we_i,
    input  logic [CVA6Cfg.DCACHE_SET_ASSOC-1:0]    miss_vld_bits_i,
    input  logic [CVA6Cfg.PLEN-1:0]                miss_paddr_i,
    input  logic [2:0]                             miss_size_i,
    input  logic [CVA6Cfg.MEM_TID_WIDTH-1:0]       miss_id_i,
    input  logic [CVA6Cfg.WG_ID_WIDTH-1:0]         miss_wid_i,
    output logic                                   miss_rtrn_vld_o,
    input  logic                                   wbuffer_hit_i,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic [CVA6Cfg.PLEN-1:0]                mem_paddr_o,
    output logic [2:0]                             mem_size_o,
    output logic                                   mem_nc_o,
    output logic [CVA6Cfg.MEM_TID_WIDTH-1:0]       mem_tid_o,
    output logic [CVA6Cfg.WG_ID_WIDTH-1:0]         mem_wid_o,
    input  logic                                   mem_rtrn_vld_i,
    input  logic [CVA6Cfg.MEM_TID_WIDTH-1:0]       mem_rtrn_tid_i,
    input  logic [CVA6Cfg.DCACHE_LINE_WIDTH-1:0]   mem_rtrn_data_i,
    output logic                                   wr_cl_vld_o,
    output logic [CVA6Cfg.DCACHE_SET_ASSOC-1:0]    wr_cl_we_o,
    output logic                                   wr_cl_nc_o,
    output logic [CVA6Cfg.DCACHE_TAG_WIDTH-1:0]    wr_cl_tag_o,
    output logic [IdxW-1:0]                        wr_cl_idx_o,
    output logic [CVA6Cfg.DCACHE_OFFSET_WIDTH-1:0] wr_cl_off_o,
    output logic [CVA6Cfg.DCACHE_LINE_WIDTH-1:0]   wr_cl_data_o,
    output logic [CVA6Cfg.DCACHE_SET_ASSOC-1:0]    wr_vld_bits_o
);
    localparam int unsigned SA = CVA6Cfg.DCACHE_SET_ASSOC;
    localparam int unsigned PLEN = CVA6Cfg.PLEN;
    localparam int unsigned OFF = CVA6Cfg.DCACHE_OFFSET_WIDTH;
    localparam int unsigned TAG = CVA6Cfg.DCACHE_TAG_WIDTH;

    miss_state_e      state_q;
    miss_info_t       info_q;
    logic [WAY_W-1:0] rr_q, way_sel;
    logic [SA-1:0]    way_oh;
    logic             all_vld, rtrn_hit, unused_in;

    assign unused_in = ^{miss_we_i, miss_id_i};

    wt_dcache_way_sel #(.SetAssoc(SA)) i_way_sel (
        .vld_bits(miss_vld_bits_i),
        .rr_cnt  (rr_q),
        .way     (way_sel),
        .all_vld (all_vld)
    );

    always_comb begin
        miss_ack_o = state_q == IDLE && miss_req_i && !wbuffer_hit_i;
        miss_replay_o = state_q == IDLE && miss_req_i && wbuffer_hit_i;
        mem_req_o = state_q == MEM_REQ;
        // payload is forced to zero outside MEM_REQ so idle outputs stay quiet
        mem_paddr_o = !mem_req_o ? '0 : info_q.nc ? info_q.paddr : {info_q.paddr[PLEN-1:OFF], {OFF{1'b0}}};
        mem_size_o = !mem_req_o ? 3'b000 : info_q.nc ? info_q.size : 3'b111;
        mem_nc_o = mem_req_o && info_q.nc;
        mem_tid_o = mem_req_o ? RdTxId : '0;
        mem_wid_o = mem_req_o ? info_q.wid : '0;
        rtrn_hit = state_q == WAIT_RTRN && mem_rtrn_vld_i && mem_rtrn_tid_i == RdTxId;
        way_oh = SA'(1) << info_q.way;
        miss_rtrn_vld_o = rtrn_hit;
        wr_cl_vld_o = rtrn_hit;
        wr_cl_we_o = rtrn_hit && !info_q.nc ? way_oh : '0;
        wr_cl_nc_o = rtrn_hit && info_q.nc;
        wr_cl_tag_o = rtrn_hit ? info_q.paddr[PLEN-1 -: TAG] : '0;
        wr_cl_idx_o = rtrn_hit ? info_q.paddr[OFF +: IdxW] : '0;
        wr_cl_off_o = rtrn_hit && info_q.nc ? info_q.paddr[OFF-1:0] : '0;
        wr_cl_data_o = rtrn_hit ? mem_rtrn_data_i : '0;
        wr_vld_bits_o = !rtrn_hit ? '0 : info_q.nc ? info_q.vld_bits : info_q.vld_bits | way_oh;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            info_q <= '0;
            rr_q <= '0;
        end else if (miss_ack_o) begin
            state_q <= MEM_REQ;
            info_q <= '{paddr: miss_paddr_i, nc: miss_nc_i, size: miss_size_i, wid: miss_wid_i,
                        vld_bits: miss_vld_bits_i, way: way_sel};
            if (all_vld && !miss_nc_i) rr_q <= rr_q + WAY_W'(1);
        end else if (mem_req_o && mem_gnt_i) begin
            state_q <= WAIT_RTRN;
        end else if (rtrn_hit) begin
            state_q <= IDLE;
        end
    end
endmodule
